opl_timer_bank: RTL and testbench
=================================

OPL_TIMER_BANK -- requirements
Module: opl_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 2, giving the number of timers (legal 1..3).
REQ-002 SHALL have parameter CLK_DIV, default 14, giving clk cycles per microtick (legal 1..64).
REQ-003 SHALL have parameter RES0, default 80, giving microticks per count for timer 0 (legal 1..512).
REQ-004 SHALL have parameter RES_MULT, default 4, so timer i uses RES0*RES_MULT^i microticks per count (result 1..4096).
REQ-005 SHALL have parameter CTRL_REG, default 8'h04, giving the control register index.
REQ-006 SHALL have parameter CLR_ON_READ, default 0; when 1, status reads clear the flags.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-009 addr  in  1  0 = index/status port, 1 = data port.
REQ-010 din  in  8  write data.
REQ-011 we  in  1  write strobe; level, acted on at its rising edge only.
REQ-012 rd  in  1  read strobe; level, acted on at its rising edge only.
REQ-013 dout  out  8  status byte, combinational from flags.
REQ-014 irq_n  out  1  low while any flag is set.

Function
REQ-015 SHALL detect write edge as we & ~we_q, and read edge as rd & ~rd_q, with we_q/rd_q registered.
REQ-016 Write edge with addr=0 SHALL latch din into the 8-bit index register.
REQ-017 Write edge with addr=1 and index 8'h02+i (i<NUM_TIMERS) SHALL load preset[i] with din.
REQ-018 Write edge with addr=1 and index CTRL_REG, din[7]=1 SHALL clear all flags and leave mask/start unchanged.
REQ-019 Write edge with addr=1 and index CTRL_REG, din[7]=0 SHALL load mask[i]=din[6-i] and start[i]=din[i], and clear flag[i] where the new mask[i]=1.
REQ-020 Writes to any other index SHALL be ignored.
REQ-021 A free-running prescaler SHALL pulse ce for one clk every CLK_DIV clks, counting from reset release.
REQ-022 Timer i with start[i]=0 SHALL hold count[i]=preset[i] and sub[i]=RES_i-1 every clk.
REQ-023 Timer i with start[i]=1, on each ce: sub decrements; at sub=0, sub reloads RES_i-1 and count increments.
REQ-024 When count=8'hFF increments, count SHALL reload preset[i] (no 8-bit wrap to 0) and pulse ovf[i] for one clk.
REQ-025 Overflow period SHALL be (256-preset[i])*RES_i ce pulses, counted from the first ce after start rises.
REQ-026 ovf[i] with mask[i]=0 SHALL set flag[i] on the next edge; with mask[i]=1 SHALL be discarded.
REQ-027 Set and clear of the same flag in one clk: set wins.
REQ-028 Preset writes while running SHALL take effect at the next reload only.
REQ-029 dout[7] SHALL be OR of flags, dout[6-i] SHALL be flag[i], and all other bits 0.
REQ-030 irq_n SHALL be ~(OR of flags).
REQ-031 With CLR_ON_READ=1, a read edge with addr=0 SHALL clear all flags one clk later; a simultaneous set still wins.
REQ-032 Timers SHALL be fully independent; simultaneous overflows SHALL set each flag.

Reset
REQ-033 rst=1 SHALL asynchronously clear index, presets, mask, start, flags, counts, we_q/rd_q and prescaler, and load every sub with RES_i-1.
REQ-034 During reset dout SHALL be 8'h00 and irq_n 1; reset mid-count SHALL abort with no flag.
REQ-035 After rst falls, the first write edge SHALL be honoured on the first clk.

Verification (CLK_DIV=1, RES0=2, RES_MULT=4 unless stated)
REQ-036 Preset 0xFE, ctrl 0x01 -> flag0 sets after exactly 4 ce; dout=0xC0; irq_n=0; repeats every 4 ce.
REQ-037 Preset1=0xFF, ctrl 0x02 -> dout=0xA0 after 8 ce; ctrl 0x80 -> dout=0x00, timer keeps running.
REQ-038 Ctrl 0x41 (mask0) -> no flag; then ctrl 0x01 -> flag0 follows on the next overflow.
REQ-039 Clear write on the same clk as ovf0 -> flag0 remains 1.
REQ-040 CLR_ON_READ=1: flag set, rd pulse at addr=0 -> dout=0x00 next clk; at CLR_ON_READ=0 -> unchanged.
REQ-041 rst asserted mid-count, then released -> outputs 00/1; counting does not resume until start is rewritten.

Source files
------------

// File: rtl/opl_timer_bank.sv
// -----------------------------------------------------------------------------
// opl_timer_bank
//   A bank of OPL-style 8-bit up-counting timers behind a two-address
//   index/data register port. A shared prescaler produces a clock enable (ce)
//   every CLK_DIV clocks. Each timer divides ce by its own resolution
//   RES_i = RES0 * RES_MULT^i. It then counts from its preset up to 8'hFF.
//   When the count passes 8'hFF, the timer reloads the preset and raises an
//   overflow. An unmasked overflow sets a sticky status flag.
//
// Ports
//   clk    : sole clock, rising edge
//   rst    : asynchronous active-high reset
//   addr   : 0 = index/status port, 1 = data port
//   din    : write data
//   we     : write strobe (level; acted on at its rising edge)
//   rd     : read strobe  (level; acted on at its rising edge)
//   dout   : status byte {any_flag, flag[0], flag[1], flag[2], 0000}
//   irq_n  : low while any flag is set
// -----------------------------------------------------------------------------
module opl_timer_bank #(
    parameter int          NUM_TIMERS  = 2,
    parameter int          CLK_DIV     = 14,
    parameter int          RES0        = 80,
    parameter int          RES_MULT    = 4,
    parameter logic [7:0]  CTRL_REG    = 8'h04,
    parameter bit          CLR_ON_READ = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       addr,
    input  logic [7:0] din,
    input  logic       we,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       irq_n
);

    localparam int PRE_W = 7;   // holds 0..63
    localparam int SUB_W = 12;  // holds RES_i-1 up to 4095

    // Reload value of the sub-count divider for timer i (RES_i - 1).
    function automatic logic [SUB_W-1:0] res_reload(input int i);
        int r;
        r = RES0;
        for (int k = 0; k < i; k++) begin
            r = r * RES_MULT;
        end
        return SUB_W'(r - 1);
    endfunction

    logic [7:0]            index_q;
    logic                  we_q;
    logic                  rd_q;
    logic [NUM_TIMERS-1:0] mask;
    logic [NUM_TIMERS-1:0] start;
    logic [NUM_TIMERS-1:0] flag;
    logic [NUM_TIMERS-1:0] ovf;
    logic [NUM_TIMERS-1:0] new_mask;
    logic [NUM_TIMERS-1:0] new_start;
    logic [NUM_TIMERS-1:0] flag_set;
    logic [NUM_TIMERS-1:0] flag_clr;
    logic [PRE_W-1:0]      pre_cnt;
    logic                  ce;
    logic                  we_edge;
    logic                  rd_edge;
    logic                  wr_ctrl;
    logic                  ctrl_clr_all;
    logic                  ctrl_load;

    // Strobes are levels; only their rising edge is acted on.
    assign we_edge      = we & ~we_q;
    assign rd_edge      = rd & ~rd_q;
    assign wr_ctrl      = we_edge & addr & (index_q == CTRL_REG);
    assign ctrl_clr_all = wr_ctrl & din[7];
    assign ctrl_load    = wr_ctrl & ~din[7];

    // Control byte layout: mask bits count down from bit 6, start bits count
    // up from bit 0.
    always_comb begin
        new_mask  = '0;
        new_start = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            new_mask[i]  = din[6-i];
            new_start[i] = din[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= 8'h00;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            mask    <= '0;
            start   <= '0;
        end else begin
            we_q <= we;
            rd_q <= rd;
            if (we_edge && !addr) begin
                index_q <= din;
            end
            if (ctrl_load) begin
                mask  <= new_mask;
                start <= new_start;
            end
        end
    end

    // Free-running prescaler; ce is high for the last clock of each period.
    assign ce = (pre_cnt == PRE_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (ce) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_timer
        localparam logic [SUB_W-1:0] RELOAD = res_reload(g);

        logic [7:0]       preset_r;
        logic [7:0]       count_r;
        logic [SUB_W-1:0] sub_r;
        logic             preset_we;

        assign preset_we = we_edge & addr & (index_q == 8'(2 + g));

        // Overflow fires in the cycle whose ce takes the count past 8'hFF.
        assign ovf[g] = start[g] & ce & (sub_r == '0) & (count_r == 8'hFF);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                preset_r <= 8'h00;
                count_r  <= 8'h00;
                sub_r    <= RELOAD;
            end else begin
                if (preset_we) begin
                    preset_r <= din;
                end
                // A stopped timer tracks its preset, so the first period
                // after start is a full one. A running timer only samples
                // the preset when it reloads.
                if (!start[g]) begin
                    count_r <= preset_r;
                    sub_r   <= RELOAD;
                end else if (ce) begin
                    if (sub_r == '0) begin
                        sub_r   <= RELOAD;
                        count_r <= (count_r == 8'hFF) ? preset_r : count_r + 8'h01;
                    end else begin
                        sub_r <= sub_r - 1'b1;
                    end
                end
            end
        end
    end

    // Flag update: clears from the control register and, optionally, from a
    // status read; a same-cycle set always wins.
    always_comb begin
        flag_set = ovf & ~mask;
        flag_clr = '0;
        if (ctrl_clr_all) begin
            flag_clr = '1;
        end
        if (ctrl_load) begin
            flag_clr = flag_clr | new_mask;
        end
        if (CLR_ON_READ && rd_edge && !addr) begin
            flag_clr = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= '0;
        end else begin
            flag <= (flag & ~flag_clr) | flag_set;
        end
    end

    always_comb begin
        dout    = 8'h00;
        dout[7] = |flag;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            dout[6-i] = flag[i];
        end
    end

    assign irq_n = ~(|flag);

endmodule

// File: tb/tb_opl_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_opl_timer_bank
//   Directed bench for opl_timer_bank. Three instances share one register bus:
//     u_dut : CLK_DIV=1, RES0=2, RES_MULT=4, two timers, CLR_ON_READ=0
//     u_cor : same as u_dut, CLR_ON_READ=1
//     u_div : CLK_DIV=3, RES0=1, RES_MULT=1, one timer (prescaler phase)
//   Times below are written relative to W, the clock edge where the control
//   write that starts the timers is acted on.
// -----------------------------------------------------------------------------
module tb_opl_timer_bank;

    logic       clk;
    logic       rst;
    logic       addr;
    logic [7:0] din;
    logic       we;
    logic       rd;
    logic [7:0] dout_m, dout_c, dout_d;
    logic       irq_m, irq_c, irq_d;

    int n_vec;
    int n_bad;
    int cyc;
    int last_w;

    opl_timer_bank #(
        .NUM_TIMERS(2), .CLK_DIV(1), .RES0(2), .RES_MULT(4),
        .CTRL_REG(8'h04), .CLR_ON_READ(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .rd(rd),
        .dout(dout_m), .irq_n(irq_m)
    );

    opl_timer_bank #(
        .NUM_TIMERS(2), .CLK_DIV(1), .RES0(2), .RES_MULT(4),
        .CTRL_REG(8'h04), .CLR_ON_READ(1'b1)
    ) u_cor (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .rd(rd),
        .dout(dout_c), .irq_n(irq_c)
    );

    opl_timer_bank #(
        .NUM_TIMERS(1), .CLK_DIV(3), .RES0(1), .RES_MULT(1),
        .CTRL_REG(8'h04), .CLR_ON_READ(1'b0)
    ) u_div (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .rd(rd),
        .dout(dout_d), .irq_n(irq_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release: edge k makes cyc == k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Register write: the first edge acts on it, the second lets we fall.
    task automatic wr(input logic a, input logic [7:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        tick();
        last_w = cyc;
        we = 1'b0;
        tick();
    endtask

    task automatic rd_pulse();
        addr = 1'b0;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        we   = 1'b0;
        rd   = 1'b0;
        addr = 1'b0;
        din  = 8'h00;
        #1;
        chk("rst_dout", dout_m, 8'h00);
        chk("rst_irq", {7'b0, irq_m}, 8'h01);
        ticks(2);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Preset timer0 to 0xFE and start it alone; returns at W+1.
    task automatic start_t0();
        wr(1'b0, 8'h02);
        wr(1'b1, 8'hFE);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        n_vec = 0;
        n_bad = 0;
        last_w = 0;
        rst = 1'b1;
        we = 1'b0;
        rd = 1'b0;
        addr = 1'b0;
        din = 8'h00;

        // Prescaler phase: u_div has ce on edges k with k%3==0; RES=1 and
        // preset FE give FF on the first ce after W and overflow on the second.
        do_reset();
        start_t0();
        a = last_w + (3 - (last_w % 3));
        b = a + 3;
        while (cyc < b - 1) tick();
        chk("div_before", {7'b0, irq_d}, 8'h01);
        tick();
        chk("div_flag_irq", {7'b0, irq_d}, 8'h00);
        chk("div_flag_dout", dout_d, 8'hC0);

        // Timer0, preset FE, RES 2: flag every 4 ce.
        do_reset();
        start_t0();
        ticks(2);
        chk("t0_w3", dout_m, 8'h00);
        tick();
        chk("t0_w4_dout", dout_m, 8'hC0);
        chk("t0_w4_irq", {7'b0, irq_m}, 8'h00);
        chk("t0_w4_cor", dout_c, 8'hC0);
        wr(1'b1, 8'h80);
        chk("t0_clr_w6", dout_m, 8'h00);
        tick();
        chk("t0_w7", dout_m, 8'h00);
        tick();
        chk("t0_w8_repeat", dout_m, 8'hC0);

        // Timer1, preset FF, RES 8: flag every 8 ce; clear keeps it running.
        do_reset();
        wr(1'b0, 8'h03);
        wr(1'b1, 8'hFF);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h02);
        ticks(6);
        chk("t1_w7", dout_m, 8'h00);
        tick();
        chk("t1_w8", dout_m, 8'hA0);
        wr(1'b1, 8'h80);
        chk("t1_clr_w10", dout_m, 8'h00);
        ticks(5);
        chk("t1_w15", dout_m, 8'h00);
        tick();
        chk("t1_w16", dout_m, 8'hA0);

        // Mask: ctrl 41 discards overflows; ctrl 01 unmasks while running.
        do_reset();
        wr(1'b0, 8'h02);
        wr(1'b1, 8'hFE);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h41);
        ticks(5);
        chk("mask_w6", dout_m, 8'h00);
        wr(1'b1, 8'h01);
        chk("unmask_w8", dout_m, 8'hC0);
        wr(1'b1, 8'h41);
        chk("remask_clr_w10", dout_m, 8'h00);
        ticks(2);
        chk("remask_w12", dout_m, 8'h00);

        // Clear write on the overflow edge W+8: set wins.
        do_reset();
        start_t0();
        ticks(6);
        chk("sw_w7", dout_m, 8'hC0);
        wr(1'b1, 8'h80);
        chk("sw_set_wins", dout_m, 8'hC0);
        // Status read at W+10: only the clear-on-read instance drops its flag.
        rd_pulse();
        chk("cor0_keep", dout_m, 8'hC0);
        chk("cor1_clear", dout_c, 8'h00);
        chk("cor1_irq", {7'b0, irq_c}, 8'h01);

        // Both timers overflow together at W+8.
        do_reset();
        wr(1'b0, 8'h02);
        wr(1'b1, 8'hFE);
        wr(1'b0, 8'h03);
        wr(1'b1, 8'hFF);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h03);
        ticks(6);
        chk("both_w7", dout_m, 8'hC0);
        tick();
        chk("both_w8", dout_m, 8'hE0);

        // Preset FC written at W+5 applies only from the W+8 reload.
        do_reset();
        start_t0();
        tick();
        wr(1'b0, 8'h02);
        wr(1'b1, 8'hFC);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h80);
        chk("pre_clr_w10", dout_m, 8'h00);
        ticks(5);
        chk("pre_w15", dout_m, 8'h00);
        tick();
        chk("pre_w16", dout_m, 8'hC0);

        // Reset with a flag set, a write held across release, no restart.
        do_reset();
        start_t0();
        ticks(4);
        chk("mid_flag", dout_m, 8'hC0);
        #2;
        rst  = 1'b1;
        addr = 1'b0;
        din  = 8'h02;
        we   = 1'b1;
        #1;
        chk("async_dout", dout_m, 8'h00);
        chk("async_irq", {7'b0, irq_m}, 8'h01);
        ticks(2);
        @(negedge clk);
        rst = 1'b0;
        tick();
        we = 1'b0;
        tick();
        wr(1'b1, 8'hFE);
        ticks(10);
        chk("no_resume", dout_m, 8'h00);
        chk("no_resume_irq", {7'b0, irq_m}, 8'h01);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h01);
        ticks(2);
        chk("restart_w3", dout_m, 8'h00);
        tick();
        chk("restart_w4", dout_m, 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
